mux_sel_seq: RTL and testbench



---
 rtl/mux_sel_seq_if.sv | 22 ++
 rtl/mux_sel_seq.sv | 118 +++++++++++
 tb/tb_mux_sel_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mux_sel_seq_if.sv
// Byte/select bus between the select sequencer and its producer; the mux taps i_bus/sel.
// master = byte producer, slave = sequencer.
interface mux_sel_seq_if;
    logic       load;
    logic [7:0] din;
    logic       ready;
    logic [7:0] i_bus;
    logic [2:0] sel;
    logic       bit_strobe;
    logic       busy;
    logic       done;

    modport master (
        output load, din,
        input  ready, i_bus, sel, bit_strobe, busy, done
    );

    modport slave (
        input  load, din,
        output ready, i_bus, sel, bit_strobe, busy, done
    );
endinterface

// File: rtl/mux_sel_seq.sv
// Select sequencer: holds a byte on i_bus and walks sel across all 8 bits, CLKS_PER_BIT clocks each.
// Latency: first bit on the accepting edge, done 8*CLKS_PER_BIT clocks later, ready one clock after that.
// Backpressure: ready drops for the whole frame; load while not ready is dropped, never queued.
module mux_sel_seq #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    mux_sel_seq_if.slave bus
);

    localparam int             DW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     SEL_FIRST  = MSB_FIRST ? 3'd7 : 3'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    i_bus_q, i_bus_d;
    logic [2:0]    sel_q, sel_d;
    logic          strobe_q, strobe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= 3'd0;
            i_bus_q  <= 8'h00;
            sel_q    <= 3'd0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            i_bus_q  <= i_bus_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // Strobe and done are single-cycle pulses; everything else holds unless a transition moves it.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        i_bus_d  = i_bus_q;
        sel_d    = sel_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ready_d  = ready_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.load) begin
                    state_d  = SHIFT;
                    i_bus_d  = bus.din;
                    sel_d    = SEL_FIRST;
                    div_d    = '0;
                    cnt_d    = 3'd0;
                    busy_d   = 1'b1;
                    strobe_d = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (cnt_q != 3'd7) begin
                        sel_d    = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
                        cnt_d    = cnt_q + 3'd1;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.ready      = ready_q;
    assign bus.i_bus      = i_bus_q;
    assign bus.sel        = sel_q;
    assign bus.bit_strobe = strobe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed bench: DUT A (4 clocks/bit, LSB first) and DUT B (1 clock/bit, MSB first) share clk/rst.
// Cycle t of a frame is the cycle starting at the t-th edge after the accepting edge; outputs read at negedge.
module tb_mux_sel_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mux_sel_seq_if a_if ();
    mux_sel_seq_if b_if ();

    mux_sel_seq #(.CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mux_sel_seq #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {ready, busy, done, bit_strobe, sel[2:0], i_bus[7:0]}
    function automatic logic [14:0] obs(input int dut);
        if (dut == 0)
            return {a_if.ready, a_if.busy, a_if.done, a_if.bit_strobe, a_if.sel, a_if.i_bus};
        return {b_if.ready, b_if.busy, b_if.done, b_if.bit_strobe, b_if.sel, b_if.i_bus};
    endfunction

    task automatic drive(input int dut, input logic ld, input logic [7:0] d);
        if (dut == 0) begin
            a_if.load = ld;
            a_if.din  = d;
        end else begin
            b_if.load = ld;
            b_if.din  = d;
        end
    endtask

    task automatic chk_idle(input string tag, input int dut, input logic [2:0] esel, input logic [7:0] ebus);
        logic [14:0] o;
        o = obs(dut);
        chk({tag, " ready"},  o[14],   1);
        chk({tag, " busy"},   o[13],   0);
        chk({tag, " done"},   o[12],   0);
        chk({tag, " strobe"}, o[11],   0);
        chk({tag, " sel"},    o[10:8], esel);
        chk({tag, " i_bus"},  o[7:0],  ebus);
    endtask

    // Loads d, then checks every cycle through ready's return.
    // ign_at: pulse load with FF in that cycle; abort_at: assert rst in that cycle and stop; hold: keep load high.
    task automatic run_frame(input int dut, input logic [7:0] d, input int ign_at, input int abort_at, input bit hold);
        int          cpb;
        int          n;
        int          k;
        logic [14:0] o;
        logic [2:0]  es;
        logic [2:0]  fin;
        string       p;
        cpb = (dut == 0) ? 4 : 1;
        n   = 8 * cpb;
        fin = (dut == 0) ? 3'd7 : 3'd0;
        drive(dut, 1'b1, d);
        @(posedge clk);
        for (int t = 0; t <= n + 1; t++) begin
            @(negedge clk);
            p = $sformatf("%s d%02h t%0d", (dut == 0) ? "A" : "B", d, t);
            if (t == abort_at) begin
                drive(dut, 1'b0, 8'h00);
                rst = 1'b1;
                #1;
                chk_idle({p, " async rst"}, dut, 3'd0, 8'h00);
                repeat (3) begin
                    @(negedge clk);
                    o = obs(dut);
                    chk({p, " rst no done"}, o[12], 0);
                end
                rst = 1'b0;
                return;
            end
            o = obs(dut);
            if (t < n) begin
                k  = t / cpb;
                es = (dut == 0) ? 3'(k) : 3'(7 - k);
                chk({p, " sel"},    o[10:8], es);
                chk({p, " strobe"}, o[11],   (t % cpb) == 0);
                chk({p, " busy"},   o[13],   1);
                chk({p, " ready"},  o[14],   0);
                chk({p, " done"},   o[12],   0);
                chk({p, " i_bus"},  o[7:0],  d);
                chk({p, " y"},      o[o[10:8]], d[es]);
            end else if (t == n) begin
                chk({p, " done"},   o[12],   1);
                chk({p, " busy"},   o[13],   0);
                chk({p, " ready"},  o[14],   0);
                chk({p, " strobe"}, o[11],   0);
                chk({p, " sel"},    o[10:8], fin);
                chk({p, " i_bus"},  o[7:0],  d);
            end else begin
                chk_idle({p, " end"}, dut, fin, d);
            end
            drive(dut, hold || (t == ign_at), (t == ign_at) ? 8'hFF : 8'hE7);
        end
    endtask

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk_idle("A in rst", 0, 3'd0, 8'h00);
        chk_idle("B in rst", 1, 3'd0, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle($sformatf("A idle%0d", i), 0, 3'd0, 8'h00);
            chk_idle($sformatf("B idle%0d", i), 1, 3'd0, 8'h00);
        end

        // y reads 1,0,1,0,0,1,0,1
        run_frame(0, 8'hA5, -1, -1, 1'b0);
        // y reads 0,0,1,1,1,1,0,0
        run_frame(1, 8'h3C, -1, -1, 1'b0);
        // load of FF mid-frame must be dropped
        run_frame(0, 8'h81, 5, -1, 1'b0);
        // reset at T0+10 aborts with no done; a fresh frame then runs clean
        run_frame(0, 8'h6E, -1, 10, 1'b0);
        chk_idle("A after abort", 0, 3'd0, 8'h00);
        run_frame(0, 8'h01, -1, -1, 1'b0);
        // load held high: second frame begins on the first edge that sees ready
        run_frame(0, 8'hC3, -1, -1, 1'b1);
        run_frame(0, 8'h5A, -1, -1, 1'b0);
        run_frame(1, 8'h96, -1, -1, 1'b1);
        run_frame(1, 8'h0F, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
